// File: rtl/wrapper_ahb_reg_bridge.sv
// AHB-Lite slave to register-interface bridge for accelerator wrappers.
// Each accepted transfer becomes a held read_en/write_en request that completes on
// rready/wready. Bad size/alignment, slverr and wait timeout give a two-cycle ERROR.
module wrapper_ahb_reg_bridge #(
    parameter int unsigned ADDRWIDTH = 12,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   hsels,
    input  logic [ADDRWIDTH-1:0]   haddrs,
    input  logic [1:0]             htranss,
    input  logic [2:0]             hsizes,
    input  logic                   hwrites,
    input  logic                   hreadys,
    input  logic [DATAWIDTH-1:0]   hwdatas,
    output logic                   hreadyouts,
    output logic                   hresps,
    output logic [DATAWIDTH-1:0]   hrdatas,
    output logic [ADDRWIDTH-1:0]   addr,
    output logic                   read_en,
    output logic                   write_en,
    output logic [DATAWIDTH/8-1:0] byte_strobe,
    output logic [DATAWIDTH-1:0]   wdata,
    input  logic [DATAWIDTH-1:0]   rdata,
    input  logic                   rready,
    input  logic                   wready,
    input  logic                   slverr
);

    localparam int unsigned STRBW = DATAWIDTH / 8;
    localparam int unsigned OFFW  = $clog2(STRBW);
    localparam int unsigned CNTW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0] addr_d;
    logic [STRBW-1:0]  strb_d;

    logic              accept_c;
    logic              bad_c;
    logic              misalign_c;
    logic [OFFW-1:0]   offset_c;
    logic [STRBW-1:0]  lanes_c;
    logic              decode_c;

    // Write data passes straight through in the data phase.
    assign wdata = hwdatas;

    // Address-phase decode: acceptance, size/alignment check and lane mask.
    always_comb begin
        accept_c   = hsels & hreadys & htranss[1];
        offset_c   = haddrs[OFFW-1:0];
        misalign_c = 1'b0;
        for (int i = 0; i < int'(OFFW); i++) begin
            if (3'(i) < hsizes) misalign_c = misalign_c | offset_c[i];
        end
        bad_c = (hsizes > 3'(OFFW)) | misalign_c;
        // A lane is enabled when it falls in the same size-aligned block as the offset.
        for (int b = 0; b < int'(STRBW); b++) begin
            lanes_c[b] = ((OFFW'(b) >> hsizes) == (offset_c >> hsizes)) & ~bad_c;
        end
    end

    // Next-state, counter and bus response logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr;
        strb_d     = byte_strobe;
        hreadyouts = 1'b1;
        hresps     = 1'b0;
        hrdatas    = '0;
        decode_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                decode_c = 1'b1;
            end
            ST_RD: begin
                hreadyouts = 1'b0;
                if (rready) begin
                    if (slverr) begin
                        state_d = ST_ERR1;
                    end else begin
                        hreadyouts = 1'b1;
                        hrdatas    = rdata;
                        state_d    = ST_IDLE;
                        decode_c   = 1'b1;
                    end
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) state_d = ST_ERR1;
                    else                   cnt_d   = cnt_q + CNTW'(1);
                end
            end
            ST_WR: begin
                hreadyouts = 1'b0;
                if (wready) begin
                    if (slverr) begin
                        state_d = ST_ERR1;
                    end else begin
                        hreadyouts = 1'b1;
                        state_d    = ST_IDLE;
                        decode_c   = 1'b1;
                    end
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) state_d = ST_ERR1;
                    else                   cnt_d   = cnt_q + CNTW'(1);
                end
            end
            ST_ERR1: begin
                hresps     = 1'b1;
                hreadyouts = 1'b0;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                hresps   = 1'b1;
                state_d  = ST_IDLE;
                decode_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new transfer may start in any cycle that ends with hreadyouts high.
        if (decode_c && accept_c) begin
            addr_d = haddrs;
            strb_d = lanes_c;
            cnt_d  = '0;
            if (bad_c)        state_d = ST_ERR1;
            else if (hwrites) state_d = ST_WR;
            else              state_d = ST_RD;
        end
    end

    // State, counter, latched address phase and request enables.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr        <= '0;
            byte_strobe <= '0;
            read_en     <= 1'b0;
            write_en    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr        <= addr_d;
            byte_strobe <= strb_d;
            read_en     <= (state_d == ST_RD);
            write_en    <= (state_d == ST_WR);
        end
    end

endmodule
